multdiv_seq: RTL and testbench

Parametrised iterative signed multiply/divide unit for the pipelined processor execute stage. Generalises the fixed 32-bit multdiv to WIDTH-bit operands.
Adds an explicit busy/stall output, abort for pipeline flush, and a deterministic latency contract.
The execute stage issues one operation, holds the pipeline while busy, and consumes the result on data_resultRDY.

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/multdiv_seq_div_step.sv | 28 ++
 rtl/multdiv_seq.sv | 265 ++++++++++++++++++++++++++
 tb/tb_multdiv_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and the latency helper for the multdiv_seq iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Edges from the capture edge to the edge that raises data_resultRDY.
    function automatic int unsigned multdiv_latency(input int unsigned width, input op_e op, input bit booth);
        if ((op == OP_MUL) && booth) begin
            return (width / 32'd2) + 32'd1;
        end else begin
            return width + 32'd1;
        end
    endfunction

endpackage

// File: rtl/multdiv_seq_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // The shifted remainder is always below 2*divisor, so WIDTH+1 bits hold it and the trial sign.
    always_comb begin
        shifted_s = {rem_in, dividend_bit};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[WIDTH] == 1'b0) begin
            quot_bit = 1'b1;
            rem_out  = trial_s[WIDTH-1:0];
        end else begin
            quot_bit = 1'b0;
            rem_out  = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed WIDTH-bit multiply/divide with busy, abort and fixed latency.
// Define MULTDIV_BOOTH_EN for radix-4 Booth multiply (WIDTH/2 steps); division is unchanged.
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_abort,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    import multdiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef MULTDIV_BOOTH_EN
    localparam int ACC_W     = WIDTH + 2;
    localparam int MUL_STEPS = WIDTH / 2;
`else
    localparam int ACC_W     = WIDTH;
    localparam int MUL_STEPS = WIDTH;
`endif

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 exc_q, exc_d;
    logic                 dz_q, dz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 exc_out_q, exc_out_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
`ifdef MULTDIV_BOOTH_EN
    logic                 lb_q, lb_d;
    logic [ACC_W-1:0]     ext_s;
    logic [ACC_W-1:0]     ext2_s;
    logic [ACC_W-1:0]     pp_s;
    logic [ACC_W-1:0]     sum_s;
`else
    logic [WIDTH:0]       sum_s;
`endif

    logic [2*WIDTH-1:0]   product_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic                 mul_ovf_s;
    logic [WIDTH-1:0]     quot_s;
    logic [WIDTH-1:0]     step_rem_s;
    logic                 step_q_s;
    logic                 a_is_min_s;
    logic                 b_is_m1_s;
    logic                 b_is_zero_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc_q[WIDTH-1:0]),
        .divisor      (mcand_q),
        .dividend_bit (lo_q[WIDTH-1]),
        .rem_out      (step_rem_s),
        .quot_bit     (step_q_s)
    );

    // Final sign correction and overflow detection from the accumulated registers.
    always_comb begin
        product_s   = {acc_q[WIDTH-1:0], lo_q};
        prod_s      = neg_q ? (~product_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : product_s;
        mul_ovf_s   = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
        quot_s      = neg_q ? (~lo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : lo_q;
        a_is_min_s  = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}});
        b_is_m1_s   = (data_operandB == {WIDTH{1'b1}});
        b_is_zero_s = (data_operandB == {WIDTH{1'b0}});
    end

    // Next-state and datapath control for the IDLE/MUL/DIV/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        exc_d     = exc_q;
        dz_d      = dz_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        res_d     = res_q;
        exc_out_d = exc_out_q;
        rdy_d     = 1'b0;
        busy_d    = busy_q;
`ifdef MULTDIV_BOOTH_EN
        lb_d      = lb_q;
        ext_s     = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        ext2_s    = {ext_s[ACC_W-2:0], 1'b0};
        case ({lo_q[1:0], lb_q})
            3'b001, 3'b010: pp_s = ext_s;
            3'b011:         pp_s = ext2_s;
            3'b100:         pp_s = ~ext2_s + {{(ACC_W-1){1'b0}}, 1'b1};
            3'b101, 3'b110: pp_s = ~ext_s + {{(ACC_W-1){1'b0}}, 1'b1};
            default:        pp_s = {ACC_W{1'b0}};
        endcase
        sum_s     = acc_q + pp_s;
`else
        sum_s     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`endif

        case (state_q)
            IDLE: begin
                if (ctrl_abort) begin
                    state_d = IDLE;
                end else if (ctrl_MULT) begin
                    op_d    = OP_MUL;
                    busy_d  = 1'b1;
                    acc_d   = {ACC_W{1'b0}};
                    exc_d   = 1'b0;
                    dz_d    = 1'b0;
                    cnt_d   = CNT_W'(MUL_STEPS);
                    state_d = MUL;
`ifdef MULTDIV_BOOTH_EN
                    // Booth works on the signed operands directly, so no sign fix-up afterwards.
                    mcand_d = data_operandA;
                    lo_d    = data_operandB;
                    neg_d   = 1'b0;
                    lb_d    = 1'b0;
`else
                    mcand_d = mag(data_operandA);
                    lo_d    = mag(data_operandB);
                    neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`endif
                end else if (ctrl_DIV) begin
                    op_d    = OP_DIV;
                    busy_d  = 1'b1;
                    acc_d   = {ACC_W{1'b0}};
                    mcand_d = mag(data_operandB);
                    lo_d    = mag(data_operandA);
                    neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    exc_d   = a_is_min_s & b_is_m1_s;
                    dz_d    = b_is_zero_s;
                    cnt_d   = CNT_W'(WIDTH);
                    if (b_is_zero_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (ctrl_abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
`ifdef MULTDIV_BOOTH_EN
                    acc_d = {{2{sum_s[ACC_W-1]}}, sum_s[ACC_W-1:2]};
                    lo_d  = {sum_s[1:0], lo_q[WIDTH-1:2]};
                    lb_d  = lo_q[1];
`else
                    acc_d = sum_s[WIDTH:1];
                    lo_d  = {sum_s[0], lo_q[WIDTH-1:1]};
`endif
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            DIV: begin
                if (ctrl_abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // lo_q shifts dividend bits out of the top and quotient bits in at the bottom.
                    acc_d = ACC_W'(step_rem_s);
                    lo_d  = {lo_q[WIDTH-2:0], step_q_s};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (ctrl_abort) begin
                    rdy_d = 1'b0;
                end else if (op_q == OP_MUL) begin
                    rdy_d     = 1'b1;
                    res_d     = prod_s[WIDTH-1:0];
                    exc_out_d = mul_ovf_s;
                end else if (dz_q) begin
                    rdy_d     = 1'b1;
                    res_d     = {WIDTH{1'b0}};
                    exc_out_d = 1'b1;
                end else begin
                    rdy_d     = 1'b1;
                    res_d     = quot_s;
                    exc_out_d = exc_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            exc_q     <= 1'b0;
            dz_q      <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            res_q     <= {WIDTH{1'b0}};
            exc_out_q <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
            lb_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            exc_q     <= exc_d;
            dz_q      <= dz_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            res_q     <= res_d;
            exc_out_q <= exc_out_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
`ifdef MULTDIV_BOOTH_EN
            lb_q      <= lb_d;
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_out_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq (WIDTH=32); follows MULTDIV_BOOTH_EN for multiply latency.
module tb_multdiv_seq;
    import multdiv_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        ctrl_abort;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int failures;
    bit booth;
    int lat_mul;
    int lat_div;

    multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_abort     (ctrl_abort),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic do_mul, input logic do_div,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        int  n;
        int  busy_drop;
        bit  seen;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = do_mul;
        ctrl_DIV      = do_div;
        tick();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h5A5A_A5A5;
        data_operandB = 32'h0000_0003;
        chk({tag, ".busy_start"}, busy, 1'b1);
        n = 0;
        seen = 1'b0;
        busy_drop = 0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (data_resultRDY === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_drop++;
        end
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".result"}, data_result, exp_res);
        chk({tag, ".exc"}, data_exception, exp_exc);
        chk({tag, ".busy_end"}, busy, 1'b0);
        chk({tag, ".busy_drop"}, busy_drop, 0);
        tick();
        chk({tag, ".rdy_pulse"}, data_resultRDY, 1'b0);
        chk({tag, ".held"}, data_result, exp_res);
    endtask

    initial begin
        int rdy_seen;
        checks = 0;
        failures = 0;
`ifdef MULTDIV_BOOTH_EN
        booth = 1'b1;
`else
        booth = 1'b0;
`endif
        lat_mul = int'(multdiv_latency(32'd32, OP_MUL, booth));
        lat_div = int'(multdiv_latency(32'd32, OP_DIV, booth));

        reset = 1'b1;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        ctrl_abort = 1'b0;
        #3;
        chk("reset.result", data_result, 32'd0);
        chk("reset.exc", data_exception, 1'b0);
        chk("reset.rdy", data_resultRDY, 1'b0);
        chk("reset.busy", busy, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle.busy", busy, 1'b0);

        run_op("mul_6_m7",     32'd6,         32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0, lat_mul);
        run_op("div_100_m7",   32'd100,       32'hFFFF_FFF9, 1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0, lat_div);
        run_op("div_m100_7",   32'hFFFF_FF9C, 32'd7,         1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0, lat_div);
        run_op("div_by_zero",  32'd5,         32'd0,         1'b0, 1'b1, 32'd0,         1'b1, 1);
        run_op("mul_ovf",      32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'd0,         1'b1, lat_mul);
        run_op("mul_m8_m9",    32'hFFFF_FFF8, 32'hFFFF_FFF7, 1'b1, 1'b0, 32'd72,        1'b0, lat_mul);
        run_op("mul_min_1",    32'h8000_0000, 32'd1,         1'b1, 1'b0, 32'h8000_0000, 1'b0, lat_mul);
        run_op("mul_min_m1",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1, lat_mul);
        run_op("mul_div_both", 32'd7,         32'hFFFF_FFFD, 1'b1, 1'b1, 32'hFFFF_FFEB, 1'b0, lat_mul);
        run_op("div_min_m1",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, lat_div);

        // Abort while IDLE suppresses a same-edge start.
        ctrl_abort = 1'b1;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd2;
        data_operandB = 32'd2;
        tick();
        ctrl_abort = 1'b0;
        ctrl_MULT = 1'b0;
        chk("idle_abort.busy", busy, 1'b0);

        // Multiply with a stray DIV at E0+5 and abort sampled at E0+10.
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        ctrl_DIV = 1'b1;
        data_operandB = 32'd0;
        tick();
        ctrl_DIV = 1'b0;
        chk("abort.busy_after_div_pulse", busy, 1'b1);
        for (int i = 6; i <= 9; i++) tick();
        chk("abort.busy_before", busy, 1'b1);
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        tick();
        chk("abort.busy_e11", busy, 1'b0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("abort.no_rdy", rdy_seen, 0);
        chk("abort.result_kept", data_result, 32'h8000_0000);
        chk("abort.exc_kept", data_exception, 1'b1);
        chk("abort.busy_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        tick();
        ctrl_MULT = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        chk("midreset.busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midreset.result", data_result, 32'd0);
        chk("midreset.exc", data_exception, 1'b0);
        chk("midreset.rdy", data_resultRDY, 1'b0);
        chk("midreset.busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("midreset.idle", busy, 1'b0);
        run_op("mul_3_4", 32'd3, 32'd4, 1'b1, 1'b0, 32'd12, 1'b0, lat_mul);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
